// File: rtl/io_input_conditioner.sv
// Switch/button front end: synchronise raw pins, debounce each bit, emit levels and press pulses.
// Define IO_EDGE_CAPTURE_EN to add sticky press flags with per-bit clear.
module io_input_conditioner #(
    parameter int NUM_SW          = 9,
    parameter int NUM_KEY         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_SW-1:0]  sw_raw_i,
    input  logic [NUM_KEY-1:0] key_raw_i,
    output logic [31:0]        sw_o,
    output logic [NUM_KEY-1:0] btn_o,
    output logic [NUM_KEY-1:0] press_pulse_o,
    output logic [NUM_KEY-1:0] press_sticky_o,
    input  logic [NUM_KEY-1:0] sticky_clr_i
);
    localparam int W  = NUM_SW + NUM_KEY;
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    // Switches idle off, keys idle released (high).
    localparam logic [W-1:0] IDLE = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};

    logic [W-1:0]       sync_q [SYNC_STAGES];
    logic [W-1:0]       sync_d [SYNC_STAGES];
    logic [W-1:0]       sync_out;
    logic [W-1:0]       stable_q, stable_d;
    logic [NUM_KEY-1:0] pulse_q, pulse_d;

    assign sync_d[0] = {key_raw_i, sw_raw_i};
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end
    assign sync_out = sync_q[SYNC_STAGES-1];

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        assign stable_d = sync_out;
    end else begin : g_deb
        localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            logic [CW-1:0] cnt_q, cnt_d;
            logic          bit_d;

            // Any sample matching the accepted level restarts the count.
            always_comb begin
                cnt_d = '0;
                bit_d = stable_q[gi];
                if (sync_out[gi] != stable_q[gi]) begin
                    if (cnt_q == CNT_LAST) begin
                        bit_d = sync_out[gi];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign stable_d[gi] = bit_d;
        end
    end

    always_comb begin
        pulse_d = stable_q[W-1:NUM_SW] & ~stable_d[W-1:NUM_SW];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= IDLE;
            end
            stable_q <= IDLE;
            pulse_q  <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            pulse_q  <= pulse_d;
        end
    end

    assign sw_o          = 32'(stable_q[NUM_SW-1:0]);
    assign btn_o         = stable_q[W-1:NUM_SW];
    assign press_pulse_o = pulse_q;

`ifdef IO_EDGE_CAPTURE_EN
    logic [NUM_KEY-1:0] sticky_q, sticky_d;

    // A pulse sets the flag even when a clear arrives in the same cycle.
    always_comb begin
        sticky_d = pulse_q | (sticky_q & ~sticky_clr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign press_sticky_o = sticky_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = ^sticky_clr_i;
    assign press_sticky_o    = '0;
`endif
endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomised + directed bench for io_input_conditioner against a window-based debounce model.
module tb_io_input_conditioner;
    localparam int NSW  = 9;
    localparam int NKEY = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int W    = NSW + NKEY;
    localparam int HL   = SYNC + DEB;
    localparam logic [W-1:0] IDLE = {{NKEY{1'b1}}, {NSW{1'b0}}};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSW-1:0]  sw_raw = 9'h1FF;
    logic [NKEY-1:0] key_raw = 4'h0;
    logic [NKEY-1:0] clr = 4'h0;
    logic [31:0]     sw_o;
    logic [NKEY-1:0] btn_o, pulse_o, sticky_o;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    io_input_conditioner #(
        .NUM_SW(NSW), .NUM_KEY(NKEY), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i(clk), .rst_i(rst), .sw_raw_i(sw_raw), .key_raw_i(key_raw),
        .sw_o(sw_o), .btn_o(btn_o), .press_pulse_o(pulse_o),
        .press_sticky_o(sticky_o), .sticky_clr_i(clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    // Model: a bit takes level v once the last DEB synchronised samples all equal v.
    // hist[j] is the pin value sampled j edges ago; the debouncer sees hist[SYNC..].
    logic [W-1:0]    hist [HL];
    logic [W-1:0]    m_s = IDLE;
    logic [W-1:0]    m_nxt;
    logic [NKEY-1:0] m_pulse = '0;
    logic [NKEY-1:0] m_sticky = '0;
    bit              all_eq;

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < HL; j++) hist[j] = IDLE;
            m_s      = IDLE;
            m_pulse  = '0;
            m_sticky = '0;
        end else begin
`ifdef IO_EDGE_CAPTURE_EN
            m_sticky = m_pulse | (m_sticky & ~clr);
`else
            m_sticky = '0;
`endif
            for (int j = HL - 1; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = {key_raw, sw_raw};
            m_nxt = m_s;
            for (int b = 0; b < W; b++) begin
                all_eq = 1'b1;
                for (int j = SYNC; j < SYNC + DEB; j++)
                    if (hist[j][b] != hist[SYNC][b]) all_eq = 1'b0;
                if (all_eq && hist[SYNC][b] != m_s[b]) m_nxt[b] = hist[SYNC][b];
            end
            m_pulse = m_s[W-1:NSW] & ~m_nxt[W-1:NSW];
            m_s     = m_nxt;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("model_sw", sw_o, 32'(m_s[NSW-1:0]));
            check("model_btn", 32'(btn_o), 32'(m_s[W-1:NSW]));
            check("model_pulse", 32'(pulse_o), 32'(m_pulse));
            check("model_sticky", 32'(sticky_o), 32'(m_sticky));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset with all pins in their non-idle state.
        step(1);
        check_en = 1'b1;
        step(2);
        check("rst_sw", sw_o, 32'h0);
        check("rst_btn", 32'(btn_o), 32'hF);
        check("rst_pulse", 32'(pulse_o), 32'h0);
        rst = 1'b0; sw_raw = '0; key_raw = 4'hF;
        step(10);

        // Switch latency: exactly SYNC+DEB cycles.
        sw_raw = 9'h155;
        step(5);
        check("sw_before", sw_o, 32'h0);
        step(1);
        check("sw_after", sw_o, 32'h0000_0155);

        // Short glitch is rejected.
        key_raw = 4'hE;
        step(3);
        key_raw = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("glitch_btn", 32'(btn_o), 32'hF);
            check("glitch_pulse", 32'(pulse_o), 32'h0);
        end

        // Held press: one pulse; release gives none.
        key_raw = 4'hE;
        step(5);
        check("press_btn_before", 32'(btn_o), 32'hF);
        step(1);
        check("press_btn", 32'(btn_o), 32'hE);
        check("press_pulse", 32'(pulse_o), 32'h1);
        step(1);
        check("press_pulse_end", 32'(pulse_o), 32'h0);
        step(3);
        key_raw = 4'hF;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("release_pulse", 32'(pulse_o), 32'h0);
        end
        check("release_btn", 32'(btn_o), 32'hF);

        // Two keys pressed together.
        key_raw = 4'h6;
        step(6);
        check("dual_pulse", 32'(pulse_o), 32'h9);
        check("dual_btn", 32'(btn_o), 32'h6);
        step(1);
        check("dual_pulse_end", 32'(pulse_o), 32'h0);
`ifdef IO_EDGE_CAPTURE_EN
        check("dual_sticky", 32'(sticky_o), 32'h9);
`endif
        key_raw = 4'hF;
        step(10);

`ifdef IO_EDGE_CAPTURE_EN
        // Clear coinciding with a pulse loses to the set.
        clr = 4'hF;
        step(1);
        clr = 4'h0;
        step(1);
        check("sticky_cleared", 32'(sticky_o), 32'h0);
        key_raw = 4'hE;
        step(6);
        clr = 4'h1;
        step(1);
        clr = 4'h0;
        check("sticky_set_wins", 32'(sticky_o[0]), 32'h1);
        step(2);
        clr = 4'h1;
        step(1);
        clr = 4'h0;
        check("sticky_clear_later", 32'(sticky_o[0]), 32'h0);
        key_raw = 4'hF;
        step(10);
`endif

        // Reset mid-count discards the pending change.
        sw_raw = 9'h0AA;
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_rst_sw", sw_o, 32'h0);
        step(5);
        check("mid_rst_sw_hold", sw_o, 32'h0);
        check("mid_rst_pulse", 32'(pulse_o), 32'h0);
        step(1);
        check("mid_rst_sw_fresh", sw_o, 32'h0000_00AA);

        // Random bounces, clears and occasional resets, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if ($urandom_range(0, 5) == 0) sw_raw[$urandom_range(0, NSW-1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) key_raw[$urandom_range(0, NKEY-1)] ^= 1'b1;
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
